tetris_spawn_ctrl: RTL and testbench

- Sequences the next-piece chart and spawns the displayed piece onto the playfield.
- On a spawn request it:
  - captures the four next-piece dots;
  - pulses the chart's update enable so the chart advances its index;
  - latches the chart's current index;
  - probes the board occupancy RAM for each dot;
  - either loads the active piece or declares game over.
- Sits between the game-logic FSM, the next-piece chart and the board store.

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/tetris_spawn_probe.sv | 62 ++++++
 rtl/tetris_spawn_ctrl.sv | 124 ++++++++++++
 tb/tb_tetris_spawn_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris spawn controller: dot field layout,
// controller state encoding, playfield defaults and the out-of-bounds test.
package tetris_pkg;
  localparam int DOT_W = 10;
  localparam int X_MSB = 9;
  localparam int X_LSB = 5;
  localparam int Y_MSB = 4;
  localparam int Y_LSB = 0;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    IDX   = 3'd2,
    CHK   = 3'd3,
    LOAD  = 3'd4,
    OVER  = 3'd5
  } state_t;

  // A dot outside the playfield counts as a collision.
  function automatic logic dot_oob(input logic [DOT_W-1:0] d, input int bw, input int bh);
    return (32'(d[X_MSB:X_LSB]) >= 32'(bw)) || (32'(d[Y_MSB:Y_LSB]) >= 32'(bh));
  endfunction
endpackage

// File: rtl/tetris_spawn_probe.sv
// Four-dot board probe: issues one read per dot, aligns the 1-cycle read
// latency and ORs occupancy/out-of-bounds into a collision flag.
// start (one cycle) clears the sequencer; done is high on the fifth active
// cycle, when coll already includes the last read's data.
module tetris_spawn_probe
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0][DOT_W-1:0] dots,
  output logic                  rd_en,
  output logic [DOT_W-1:0]      rd_addr,
  input  logic                  rd_data,
  output logic                  done,
  output logic                  coll
);
  logic             active;
  logic [2:0]       ptr;
  logic             pend;
  logic             coll_q;
  logic [DOT_W-1:0] last_addr;
  logic [1:0]       prev;
  logic             hit;

  // Read strobe/address for the current pointer; address holds between reads.
  always_comb begin
    prev    = ptr[1:0] - 2'd1;
    rd_en   = active && !ptr[2];
    rd_addr = rd_en ? dots[ptr[1:0]] : last_addr;
    hit     = pend && (rd_data || dot_oob(dots[prev], BOARD_W, BOARD_H));
    coll    = coll_q | hit;
    done    = active && ptr[2];
  end

  // Sequencer: pointer advance, pending-read alignment and collision accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      ptr       <= '0;
      pend      <= 1'b0;
      coll_q    <= 1'b0;
      last_addr <= '0;
    end else if (start) begin
      active <= 1'b1;
      ptr    <= '0;
      pend   <= 1'b0;
      coll_q <= 1'b0;
    end else if (active) begin
      pend   <= rd_en;
      coll_q <= coll;
      if (rd_en) begin
        ptr       <= ptr + 3'd1;
        last_addr <= rd_addr;
      end
      if (done) active <= 1'b0;
    end
  end
endmodule

// File: rtl/tetris_spawn_ctrl.sv
// Spawn controller: advances the next-piece chart, probes the board for the
// four candidate dots and either loads the active piece or enters game over.
// Optional successful-spawn counter: define TETRIS_SPAWN_COUNT_EN.
module tetris_spawn_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spawn_req,
  input  logic             game_restart,
  input  logic [9:0]       next_dot1,
  input  logic [9:0]       next_dot2,
  input  logic [9:0]       next_dot3,
  input  logic [9:0]       next_dot4,
  input  logic [2:0]       cur_index,
  output logic             next_update_en,
  output logic             board_rd_en,
  output logic [9:0]       board_rd_addr,
  input  logic             board_rd_data,
  output logic [9:0]       piece_dot1,
  output logic [9:0]       piece_dot2,
  output logic [9:0]       piece_dot3,
  output logic [9:0]       piece_dot4,
  output logic [2:0]       piece_index,
  output logic             piece_valid,
  output logic             busy,
  output logic             game_over,
  output logic [CNT_W-1:0] spawn_count
);
  state_t                state, state_n;
  logic [3:0][DOT_W-1:0] cand;
  logic [3:0][DOT_W-1:0] piece;
  logic [2:0]            cand_idx;
  logic                  probe_start, probe_done, probe_coll;
  logic                  load_piece;

  tetris_spawn_probe #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_probe (
    .clk     (clk),
    .rst     (rst),
    .start   (probe_start),
    .dots    (cand),
    .rd_en   (board_rd_en),
    .rd_addr (board_rd_addr),
    .rd_data (board_rd_data),
    .done    (probe_done),
    .coll    (probe_coll)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_n        = state;
    next_update_en = 1'b0;
    piece_valid    = 1'b0;
    probe_start    = 1'b0;
    case (state)
      IDLE:  if (spawn_req) state_n = FETCH;
      FETCH: begin
        next_update_en = 1'b1;
        state_n        = IDX;
      end
      IDX: begin
        probe_start = 1'b1;
        state_n     = CHK;
      end
      CHK:   if (probe_done) state_n = probe_coll ? OVER : LOAD;
      LOAD: begin
        piece_valid = 1'b1;
        state_n     = IDLE;
      end
      OVER:  if (game_restart) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state != IDLE) && (state != OVER);
  assign game_over  = (state == OVER);
  // Piece is also loaded on the way into OVER so the colliding piece can be drawn.
  assign load_piece = (state == LOAD) || ((state == CHK) && probe_done && probe_coll);

  // Candidate capture and active-piece registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      cand_idx    <= '0;
      piece       <= '0;
      piece_index <= '0;
    end else begin
      if (state == FETCH) cand <= {next_dot4, next_dot3, next_dot2, next_dot1};
      if (state == IDX)   cand_idx <= cur_index;
      if (load_piece) begin
        piece       <= cand;
        piece_index <= cand_idx;
      end
    end
  end

  assign piece_dot1 = piece[0];
  assign piece_dot2 = piece[1];
  assign piece_dot3 = piece[2];
  assign piece_dot4 = piece[3];

`ifdef TETRIS_SPAWN_COUNT_EN
  logic [CNT_W-1:0] cnt;
  // Saturating count of successful spawns; cleared when a restart is taken.
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (state == OVER && game_restart) cnt <= '0;
    else if (state == LOAD && cnt != '1)    cnt <= cnt + 1'b1;
  end
  assign spawn_count = cnt;
`else
  assign spawn_count = '0;
`endif
endmodule

// File: tb/tb_tetris_spawn_ctrl.sv
// Self-checking bench for tetris_spawn_ctrl: directed scenarios plus
// randomized spawns checked against a cycle-timeline reference model.
module tb_tetris_spawn_ctrl;
  logic       clk = 0;
  logic       rst = 1;
  logic       spawn_req = 0, game_restart = 0;
  logic [9:0] next_dot1 = 0, next_dot2 = 0, next_dot3 = 0, next_dot4 = 0;
  logic [2:0] cur_index = 0;
  logic       next_update_en, board_rd_en, board_rd_data = 0;
  logic [9:0] board_rd_addr;
  logic [9:0] piece_dot1, piece_dot2, piece_dot3, piece_dot4;
  logic [2:0] piece_index;
  logic       piece_valid, busy, game_over;
  logic [15:0] spawn_count;

  int checks = 0;
  int errors = 0;
  logic occ [1024];
  logic [2:0] chart_idx_next = 0;
  int model_cnt = 0;

  tetris_spawn_ctrl dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .game_restart(game_restart),
    .next_dot1(next_dot1), .next_dot2(next_dot2), .next_dot3(next_dot3), .next_dot4(next_dot4),
    .cur_index(cur_index), .next_update_en(next_update_en),
    .board_rd_en(board_rd_en), .board_rd_addr(board_rd_addr), .board_rd_data(board_rd_data),
    .piece_dot1(piece_dot1), .piece_dot2(piece_dot2), .piece_dot3(piece_dot3), .piece_dot4(piece_dot4),
    .piece_index(piece_index), .piece_valid(piece_valid), .busy(busy), .game_over(game_over),
    .spawn_count(spawn_count)
  );

  always #5 clk = ~clk;

  // Chart model: index advances on the update-enable edge.
  always @(posedge clk) if (next_update_en) cur_index <= chart_idx_next;

  // Board RAM model: one cycle read latency.
  always @(posedge clk) board_rd_data <= board_rd_en ? occ[board_rd_addr] : 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] mk(input int x, input int y);
    mk = {x[4:0], y[4:0]};
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 1024; i++) occ[i] = 1'b0;
  endtask

  // Spawn rule: collides if any dot is occupied or off the 10x20 board.
  function automatic bit collides(input logic [3:0][9:0] d);
    collides = 0;
    for (int i = 0; i < 4; i++)
      if (occ[d[i]] || d[i][9:5] >= 5'd10 || d[i][4:0] >= 5'd20) collides = 1;
  endfunction

  task automatic check_count(input string tag);
    int exp_cnt;
`ifdef TETRIS_SPAWN_COUNT_EN
    exp_cnt = model_cnt;
`else
    exp_cnt = 0;
`endif
    checks++;
    if (spawn_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s spawn_count got %0d want %0d", tag, spawn_count, exp_cnt);
    end
  endtask

  // One spawn request from IDLE; checks every cycle 1..9 and the loaded piece.
  task automatic run_spawn(input logic [3:0][9:0] d, input logic [2:0] idx, input string tag);
    bit ec;
    ec = collides(d);
    next_dot1 = d[0]; next_dot2 = d[1]; next_dot3 = d[2]; next_dot4 = d[3];
    chart_idx_next = idx;
    @(negedge clk); spawn_req = 1;
    @(posedge clk); #1; spawn_req = 0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (next_update_en !== (c == 1)) begin
        errors++; $display("FAIL %s next_update_en cycle %0d got %b", tag, c, next_update_en);
      end
      checks++;
      if (board_rd_en !== (c >= 3 && c <= 6)) begin
        errors++; $display("FAIL %s board_rd_en cycle %0d got %b", tag, c, board_rd_en);
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (board_rd_addr !== d[c-3]) begin
          errors++; $display("FAIL %s board_rd_addr cycle %0d got %h want %h", tag, c, board_rd_addr, d[c-3]);
        end
      end
      checks++;
      if (piece_valid !== (!ec && c == 8)) begin
        errors++; $display("FAIL %s piece_valid cycle %0d got %b", tag, c, piece_valid);
      end
      checks++;
      if (game_over !== (ec && c >= 8)) begin
        errors++; $display("FAIL %s game_over cycle %0d got %b want %b", tag, c, game_over, ec && c >= 8);
      end
      checks++;
      if (busy !== (c <= 8 && !(ec && c == 8))) begin
        errors++; $display("FAIL %s busy cycle %0d got %b", tag, c, busy);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({piece_dot4, piece_dot3, piece_dot2, piece_dot1} !== d) begin
      errors++; $display("FAIL %s piece dots got %h %h %h %h want %h", tag,
                         piece_dot1, piece_dot2, piece_dot3, piece_dot4, d);
    end
    checks++;
    if (piece_index !== idx) begin
      errors++; $display("FAIL %s piece_index got %0d want %0d", tag, piece_index, idx);
    end
    if (!ec && model_cnt < 65535) model_cnt++;
    check_count(tag);
  endtask

  task automatic do_restart(input string tag);
    @(negedge clk); game_restart = 1;
    @(posedge clk); #1; game_restart = 0;
    model_cnt = 0;
    checks++;
    if (game_over !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s restart game_over=%b busy=%b want 0 0", tag, game_over, busy);
    end
    check_count(tag);
  endtask

  task automatic test_reset();
    clear_board();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({next_update_en, board_rd_en, board_rd_addr, piece_dot1, piece_dot2, piece_dot3, piece_dot4,
         piece_index, piece_valid, busy, game_over, spawn_count} !== '0) begin
      errors++; $display("FAIL reset outputs not zero got dot1=%h idx=%0d busy=%b go=%b cnt=%0d",
                         piece_dot1, piece_index, busy, game_over, spawn_count);
    end
    @(negedge clk); rst = 0;
    model_cnt = 0;
  endtask

  task automatic test_basic();
    logic [3:0][9:0] d;
    clear_board();
    d = {mk(5,3), mk(5,2), mk(5,1), mk(5,0)};
    run_spawn(d, 3'd0, "basic");
  endtask

  task automatic test_over();
    logic [3:0][9:0] d;
    bit seen_nu, seen_pv, lost_go;
    clear_board();
    occ[mk(4,1)] = 1'b1;
    d = {mk(6,1), mk(5,1), mk(4,1), mk(4,0)};
    run_spawn(d, 3'd6, "over");
    seen_nu = 0; seen_pv = 0; lost_go = 0;
    for (int c = 0; c < 100; c++) begin
      spawn_req = (c == 20 || c == 21);
      @(posedge clk); #1;
      if (next_update_en) seen_nu = 1;
      if (piece_valid) seen_pv = 1;
      if (!game_over) lost_go = 1;
    end
    spawn_req = 0;
    checks++;
    if (lost_go) begin errors++; $display("FAIL over_hold game_over dropped got 0 want 1"); end
    checks++;
    if (seen_pv) begin errors++; $display("FAIL over_hold piece_valid got 1 want 0"); end
    checks++;
    if (seen_nu) begin errors++; $display("FAIL over_spawn next_update_en got 1 want 0"); end
  endtask

  task automatic test_restart();
    logic [3:0][9:0] d;
    bit seen;
    do_restart("restart");
    clear_board();
    d = {mk(1,3), mk(1,2), mk(0,2), mk(0,1)};
    run_spawn(d, 3'd2, "after_restart");
    // Restart and spawn together in OVER: only the restart is taken.
    d = {mk(10,0), mk(2,0), mk(1,0), mk(0,0)};
    run_spawn(d, 3'd5, "oob_x10");
    @(negedge clk); game_restart = 1; spawn_req = 1;
    @(posedge clk); #1; game_restart = 0; spawn_req = 0;
    model_cnt = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (next_update_en || busy || game_over) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL restart_and_spawn spawn_req taken got 1 want 0"); end
    check_count("restart_and_spawn");
  endtask

  task automatic test_back_to_back();
    int nu_cnt, pv_cnt;
    clear_board();
    next_dot1 = mk(5,0); next_dot2 = mk(5,1); next_dot3 = mk(5,2); next_dot4 = mk(5,3);
    chart_idx_next = 3'd1;
    nu_cnt = 0; pv_cnt = 0;
    @(negedge clk); spawn_req = 1;
    // Request held across edges 0-17: the second spawn is accepted at edge 9.
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (e == 17) spawn_req = 0;
      checks++;
      if (next_update_en !== ((e + 1) == 1 || (e + 1) == 10)) begin
        errors++; $display("FAIL back_to_back next_update_en cycle %0d got %b", e + 1, next_update_en);
      end
      checks++;
      if (piece_valid !== ((e + 1) == 8 || (e + 1) == 17)) begin
        errors++; $display("FAIL back_to_back piece_valid cycle %0d got %b", e + 1, piece_valid);
      end
    end
    model_cnt += 2;
    check_count("back_to_back");
  endtask

  task automatic test_oob();
    logic [3:0][9:0] d;
    clear_board();
    d = {mk(5,3), mk(5,2), mk(5,1), mk(12,0)};
    run_spawn(d, 3'd4, "oob_x12");
    checks++;
    if (game_over !== 1'b1) begin errors++; $display("FAIL oob_x12 game_over got 0 want 1"); end
    do_restart("oob_restart");
  endtask

  task automatic test_reset_mid();
    logic [3:0][9:0] d;
    bit seen;
    clear_board();
    next_dot1 = mk(3,0); next_dot2 = mk(3,1); next_dot3 = mk(3,2); next_dot4 = mk(3,3);
    chart_idx_next = 3'd7;
    @(negedge clk); spawn_req = 1;
    @(posedge clk); #1; spawn_req = 0;
    // Cycles 1..4 pass; assert rst in cycle 5 (third CHK cycle).
    repeat (4) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1; rst = 0;
    model_cnt = 0;
    checks++;
    if ({next_update_en, board_rd_en, board_rd_addr, piece_dot1, piece_dot2, piece_dot3, piece_dot4,
         piece_index, piece_valid, busy, game_over, spawn_count} !== '0) begin
      errors++; $display("FAIL reset_mid outputs not zero dot1=%h idx=%0d busy=%b rd=%b addr=%h",
                         piece_dot1, piece_index, busy, board_rd_en, board_rd_addr);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (piece_valid || busy) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid activity after abort got 1 want 0"); end
    d = {mk(3,3), mk(3,2), mk(3,1), mk(3,0)};
    run_spawn(d, 3'd7, "reset_mid_respawn");
  endtask

  task automatic test_random();
    logic [3:0][9:0] d;
    logic [2:0] idx;
    for (int n = 0; n < 30; n++) begin
      clear_board();
      for (int k = 0; k < 4; k++) occ[mk($urandom_range(0, 9), $urandom_range(0, 19))] = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = mk($urandom_range(0, 10), $urandom_range(0, 20));
      idx = 3'($urandom_range(0, 7));
      run_spawn(d, idx, "random");
      if (collides(d)) do_restart("random_restart");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_over();
    test_restart();
    test_back_to_back();
    test_oob();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
